// File: rtl/paddle_input_ctrl_pkg.sv
// Shared types and default timing constants for the paddle input controller.
package paddle_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        DELAY  = 2'd2,
        REPEAT = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_L    = 2'b01,
        DIR_R    = 2'b10
    } dir_e;

    localparam int DEF_REPEAT_DELAY = 12;
    localparam int DEF_REPEAT_RATE  = 4;
    localparam int DEF_CNT_W        = 6;

endpackage

// File: rtl/paddle_input_ctrl_if.sv
// Keyboard/frame-timing side of the paddle controller and its move-pulse outputs.
interface paddle_input_ctrl_if;

    logic                  frame_tick;
    logic                  enable;
    logic                  key_l;
    logic                  key_r;
    logic                  move_l;
    logic                  move_r;
    paddle_ctrl_pkg::dir_e dir;

    modport master (
        output frame_tick, enable, key_l, key_r,
        input  move_l, move_r, dir
    );

    modport slave (
        input  frame_tick, enable, key_l, key_r,
        output move_l, move_r, dir
    );

endinterface

// File: rtl/paddle_input_ctrl_key_rise_detect.sv
// Registers the previous key level and flags a 0->1 transition in the current cycle.
module key_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= key;
        end
    end

    assign rise = key & ~prev_q;

endmodule

// File: rtl/paddle_input_ctrl.sv
// Turns held Left/Right key levels into frame-aligned single-cycle move pulses:
// one pulse per press, typematic repeat after a hold delay, last-pressed key wins.
module paddle_input_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    paddle_input_ctrl_if.slave bus
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    generate
        if (REPEAT_DELAY < 1 || REPEAT_DELAY > CNT_MAX ||
            REPEAT_RATE  < 1 || REPEAT_RATE  > CNT_MAX) begin : g_bad_param
            $error("paddle_input_ctrl: repeat parameters out of range for CNT_W");
        end
    endgenerate

    logic              rise_l;
    logic              rise_r;
    logic              switch_key;
    logic              new_press;
    logic              pulse;
    logic              en_q;
    logic              move_l_q;
    logic              move_r_q;
    dir_e              act_q;
    dir_e              act_nxt;
    ctrl_state_e       state_q;
    ctrl_state_e       state_nxt;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;

    key_rise_detect u_rise_l (
        .clk   (clk),
        .reset (reset),
        .key   (bus.key_l),
        .rise  (rise_l)
    );

    key_rise_detect u_rise_r (
        .clk   (clk),
        .reset (reset),
        .key   (bus.key_r),
        .rise  (rise_r)
    );

    // Active key tracks the keyboard even while paused so re-enable picks the right key.
    always_comb begin
        act_nxt    = act_q;
        switch_key = 1'b0;
        if (rise_l) begin
            act_nxt = DIR_L;
        end else if (rise_r) begin
            act_nxt = DIR_R;
        end else if (act_q == DIR_L && !bus.key_l) begin
            act_nxt    = bus.key_r ? DIR_R : DIR_NONE;
            switch_key = bus.key_r;
        end else if (act_q == DIR_R && !bus.key_r) begin
            act_nxt    = bus.key_l ? DIR_L : DIR_NONE;
            switch_key = bus.key_l;
        end
    end

    assign new_press = rise_l | rise_r | switch_key |
                       (bus.enable & ~en_q & (act_nxt != DIR_NONE));

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Release or pause wins over everything, then a new press, then tick-driven timing.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        pulse     = 1'b0;
        if (!bus.enable || act_nxt == DIR_NONE) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (new_press) begin
            state_nxt = ARMED;
            cnt_nxt   = '0;
        end else if (bus.frame_tick) begin
            case (state_q)
                IDLE: begin
                    state_nxt = IDLE;
                end
                ARMED: begin
                    pulse     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DELAY;
                end
                DELAY: begin
                    if (cnt_inc == CNT_W'(REPEAT_DELAY)) begin
                        pulse     = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = REPEAT;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                REPEAT: begin
                    if (cnt_inc == CNT_W'(REPEAT_RATE)) begin
                        pulse   = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            act_q    <= DIR_NONE;
            en_q     <= 1'b0;
            move_l_q <= 1'b0;
            move_r_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            act_q    <= act_nxt;
            en_q     <= bus.enable;
            move_l_q <= pulse && (act_nxt == DIR_L);
            move_r_q <= pulse && (act_nxt == DIR_R);
        end
    end

    assign bus.move_l = move_l_q;
    assign bus.move_r = move_r_q;
    assign bus.dir    = (state_q == IDLE) ? DIR_NONE : act_q;

    a_move_excl: assert property (@(posedge clk) !(move_l_q && move_r_q));

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Bench for paddle_input_ctrl: vector table, frame-timed scenarios, random run vs a frame-count model.
module tb_paddle_input_ctrl;

    localparam int D = 12;
    localparam int R = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    paddle_input_ctrl_if bus ();

    paddle_input_ctrl #(
        .REPEAT_DELAY (D),
        .REPEAT_RATE  (R),
        .CNT_W        (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int frame_no;
    int pulses_l[$];
    int pulses_r[$];
    int exp_q[$];

    // Reference model: which key is active, whether it is being held, frames seen since press.
    logic       m_pl, m_pr, m_pen, m_hold;
    logic [1:0] m_act;
    int         m_k;
    logic       exp_l, exp_r;
    logic [1:0] exp_dir;

    function automatic logic fires(int k);
        if (k == 1) return 1'b1;
        if (k == 1 + D) return 1'b1;
        if (k > 1 + D && ((k - 1 - D) % R) == 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        logic kl, kr, rl, rr, sw, np;
        logic [1:0] na;
        kl = bus.key_l;
        kr = bus.key_r;
        exp_l = 1'b0;
        exp_r = 1'b0;
        if (reset) begin
            m_pl = 0; m_pr = 0; m_pen = 0; m_hold = 0; m_act = 2'b00; m_k = 0;
            exp_dir = 2'b00;
            return;
        end
        rl = kl & !m_pl;
        rr = kr & !m_pr;
        sw = 1'b0;
        na = m_act;
        if (rl) na = 2'b01;
        else if (rr) na = 2'b10;
        else if (m_act == 2'b01 && !kl) begin na = kr ? 2'b10 : 2'b00; sw = kr; end
        else if (m_act == 2'b10 && !kr) begin na = kl ? 2'b01 : 2'b00; sw = kl; end
        np = rl | rr | sw | (bus.enable & !m_pen & (na != 2'b00));
        if (!bus.enable || na == 2'b00) begin
            m_hold = 0; m_k = 0;
        end else if (np) begin
            m_hold = 1; m_k = 0;
        end else if (m_hold && bus.frame_tick) begin
            m_k++;
            if (fires(m_k)) begin
                exp_l = (na == 2'b01);
                exp_r = (na == 2'b10);
            end
        end
        exp_dir = m_hold ? na : 2'b00;
        m_pl = kl; m_pr = kr; m_pen = bus.enable; m_act = na;
    endtask

    task automatic check(string name, logic el, logic er, logic [1:0] ed);
        n_tests++;
        if (bus.move_l !== el || bus.move_r !== er || bus.dir !== ed) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got l=%b r=%b dir=%b want l=%b r=%b dir=%b",
                     name, cyc, bus.move_l, bus.move_r, bus.dir, el, er, ed);
        end
    endtask

    task automatic check_q(string name, int q[$], int e[$]);
        logic bad;
        n_tests++;
        bad = (q.size() != e.size());
        if (!bad) foreach (q[i]) if (q[i] != e[i]) bad = 1'b1;
        if (bad) begin
            n_fail++;
            $display("FAIL %s pulse frames got %p want %p", name, q, e);
        end
    endtask

    task automatic set_exp(int a, int b, int c, int d);
        exp_q.delete();
        if (a >= 0) exp_q.push_back(a);
        if (b >= 0) exp_q.push_back(b);
        if (c >= 0) exp_q.push_back(c);
        if (d >= 0) exp_q.push_back(d);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("model", exp_l, exp_r, exp_dir);
        if (bus.move_l) pulses_l.push_back(frame_no);
        if (bus.move_r) pulses_r.push_back(frame_no);
    endtask

    task automatic frames(int n, int gap);
        for (int f = 0; f < n; f++) begin
            bus.frame_tick = 1'b0;
            repeat (gap - 1) cycle();
            bus.frame_tick = 1'b1;
            frame_no++;
            cycle();
            bus.frame_tick = 1'b0;
        end
    endtask

    task automatic restart();
        pulses_l.delete();
        pulses_r.delete();
        frame_no = 0;
    endtask

    task automatic release_keys();
        bus.key_l = 1'b0;
        bus.key_r = 1'b0;
        bus.frame_tick = 1'b0;
        repeat (3) cycle();
    endtask

    typedef struct {
        logic       kl, kr, en, tk;
        logic       el, er;
        logic [1:0] ed;
    } vec_t;

    function automatic vec_t mk(logic kl, logic kr, logic en, logic tk,
                                logic el, logic er, logic [1:0] ed);
        vec_t v;
        v.kl = kl; v.kr = kr; v.en = en; v.tk = tk;
        v.el = el; v.er = er; v.ed = ed;
        return v;
    endfunction

    vec_t vt[19];

    initial begin
        vt[0]  = mk(0, 0, 1, 1,  0, 0, 2'b00);
        vt[1]  = mk(1, 0, 1, 1,  0, 0, 2'b01);  // rise with tick: not eligible
        vt[2]  = mk(1, 0, 1, 0,  0, 0, 2'b01);
        vt[3]  = mk(1, 0, 1, 1,  1, 0, 2'b01);
        vt[4]  = mk(1, 0, 1, 0,  0, 0, 2'b01);
        vt[5]  = mk(1, 1, 1, 1,  0, 0, 2'b10);  // right pressed later wins
        vt[6]  = mk(1, 1, 1, 1,  0, 1, 2'b10);
        vt[7]  = mk(1, 0, 1, 0,  0, 0, 2'b01);  // release active, switch to left
        vt[8]  = mk(1, 0, 1, 1,  1, 0, 2'b01);
        vt[9]  = mk(0, 0, 1, 1,  0, 0, 2'b00);
        vt[10] = mk(1, 1, 1, 0,  0, 0, 2'b01);  // simultaneous rise: left
        vt[11] = mk(1, 1, 1, 1,  1, 0, 2'b01);
        vt[12] = mk(1, 1, 0, 1,  0, 0, 2'b00);
        vt[13] = mk(1, 1, 0, 0,  0, 0, 2'b00);
        vt[14] = mk(1, 1, 1, 0,  0, 0, 2'b01);  // re-enable with keys held
        vt[15] = mk(1, 1, 1, 1,  1, 0, 2'b01);
        vt[16] = mk(0, 1, 1, 1,  0, 0, 2'b10);  // switch coincides with tick
        vt[17] = mk(0, 1, 1, 1,  0, 1, 2'b10);
        vt[18] = mk(0, 0, 1, 0,  0, 0, 2'b00);

        reset = 1'b1;
        bus.key_l = 1'b0;
        bus.key_r = 1'b0;
        bus.enable = 1'b1;
        bus.frame_tick = 1'b0;
        frame_no = 0;
        @(negedge clk);
        cycle();
        cycle();
        check("reset_state", 1'b0, 1'b0, 2'b00);
        reset = 1'b0;

        foreach (vt[i]) begin
            bus.key_l = vt[i].kl;
            bus.key_r = vt[i].kr;
            bus.enable = vt[i].en;
            bus.frame_tick = vt[i].tk;
            cycle();
            check($sformatf("vec%0d", i), vt[i].el, vt[i].er, vt[i].ed);
        end
        release_keys();

        // Idle after reset: nothing for 20 slow frames.
        reset = 1'b1; cycle(); reset = 1'b0;
        restart();
        frames(20, 100);
        set_exp(-1, -1, -1, -1);
        check_q("idle_l", pulses_l, exp_q);
        check_q("idle_r", pulses_r, exp_q);

        // Left held: first pulse then typematic repeat.
        restart();
        bus.key_l = 1'b1;
        frames(21, 10);
        set_exp(1, 13, 17, 21);
        check_q("hold_l", pulses_l, exp_q);
        release_keys();

        // Right pressed during a left hold takes over as a fresh press.
        restart();
        bus.key_l = 1'b1;
        frames(5, 10);
        bus.key_r = 1'b1;
        frames(15, 10);
        set_exp(1, -1, -1, -1);
        check_q("takeover_l", pulses_l, exp_q);
        set_exp(6, 18, -1, -1);
        check_q("takeover_r", pulses_r, exp_q);
        release_keys();

        // Simultaneous rise then release of left.
        restart();
        bus.key_l = 1'b1;
        bus.key_r = 1'b1;
        cycle();
        check("both_rise", 1'b0, 1'b0, 2'b01);
        bus.key_l = 1'b0;
        frames(1, 10);
        check("switch_r_pulse", 1'b0, 1'b1, 2'b10);
        release_keys();

        // Pause after the first pulse, resume with key held.
        restart();
        bus.key_r = 1'b1;
        frames(1, 10);
        bus.enable = 1'b0;
        frames(10, 10);
        bus.enable = 1'b1;
        frames(13, 10);
        set_exp(1, 12, 24, -1);
        check_q("pause_r", pulses_r, exp_q);
        release_keys();

        // Release exactly on the tick that would have repeated.
        restart();
        bus.key_l = 1'b1;
        frames(12, 10);
        repeat (9) cycle();
        bus.key_l = 1'b0;
        bus.frame_tick = 1'b1;
        frame_no++;
        cycle();
        bus.frame_tick = 1'b0;
        check("release_on_tick", 1'b0, 1'b0, 2'b00);
        set_exp(1, -1, -1, -1);
        check_q("release_l", pulses_l, exp_q);

        // Reset in the middle of repeat with the key still held.
        bus.key_l = 1'b1;
        frames(20, 10);
        reset = 1'b1;
        cycle();
        check("in_reset", 1'b0, 1'b0, 2'b00);
        cycle();
        reset = 1'b0;
        restart();
        frames(1, 10);
        set_exp(1, -1, -1, -1);
        check_q("after_reset", pulses_l, exp_q);
        release_keys();

        // Random traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.key_l = ~bus.key_l;
            if ($urandom_range(0, 49) == 0) bus.key_r = ~bus.key_r;
            bus.frame_tick = ($urandom_range(0, 2) == 0);
            if (bus.enable && $urandom_range(0, 299) == 0) bus.enable = 1'b0;
            else if (!bus.enable && $urandom_range(0, 19) == 0) bus.enable = 1'b1;
            reset = ($urandom_range(0, 999) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
